// File: rtl/lcd_char_ctrl.sv
// lcd_char_ctrl: HD44780-style character LCD controller, 8-bit or 4-bit bus.
// Optional LCD_AUTO_WRAP_EN: issue a DDRAM address command on row wrap.
module lcd_char_ctrl #(
    parameter int BUS_4BIT    = 0,
    parameter int COLS        = 16,
    parameter int ROWS        = 2,
    parameter int PWR_WAIT    = 750000,
    parameter int INIT_WAIT_1 = 205000,
    parameter int INIT_WAIT_2 = 5000,
    parameter int SETUP_WAIT  = 2,
    parameter int E_WAIT      = 12,
    parameter int CMD_WAIT    = 2000,
    parameter int CLEAR_WAIT  = 82000
) (
    input  logic       CLK_50MHZ,
    input  logic       BTN_SOUTH,
    input  logic       CHAR_VALID,
    output logic       CHAR_READY,
    input  logic [7:0] CHAR_DATA,
    input  logic       CHAR_CMD,
    output logic       INIT_DONE,
    output logic [7:0] LCD_DB,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LED
);

    localparam int INIT_N = (BUS_4BIT != 0) ? 8 : 7;

    typedef enum logic [5:0] {
        S_PWR   = 6'h01,
        S_INIT  = 6'h02,
        S_IDLE  = 6'h03,
        S_SETUP = 6'h04,
        S_EHIGH = 6'h05,
        S_HOLD  = 6'h06
`ifdef LCD_AUTO_WRAP_EN
        ,
        S_WRAP  = 6'h07
`endif
    } state_t;

    state_t      state_q;
    logic [31:0] cnt_q;
    logic [31:0] wait_q;
    logic [3:0]  idx_q;
    logic [7:0]  byte_q;
    logic [7:0]  db_q;
    logic        rs_q;
    logic        e_q;
    logic        single_q;
    logic        nib_q;
    logic        ready_q;
    logic        done_q;
    logic [5:0]  col_q;
    logic        row_q;
`ifdef LCD_AUTO_WRAP_EN
    logic        wrap_q;
    logic        wrap_d;
`endif

    logic [5:0]  col_d;
    logic        row_d;
    logic [31:0] post_d;

    logic [7:0]  init_byte;
    logic [31:0] init_wait;
    logic        init_single;

    // Bus image of a byte: full byte, or one nibble on DB[7:4].
    function automatic logic [7:0] bus_val(input logic [7:0] b,
                                           input logic low);
        logic [7:0] v;
        if (BUS_4BIT != 0) begin
            v = low ? {b[3:0], 4'h0} : {b[7:4], 4'h0};
        end else begin
            v = b;
        end
        return v;
    endfunction

    always_comb begin
        init_byte   = 8'h30;
        init_wait   = 32'(CMD_WAIT);
        init_single = 1'b0;
        if (BUS_4BIT != 0) begin
            case (idx_q)
                4'd0: begin
                    init_single = 1'b1;
                    init_wait   = 32'(INIT_WAIT_1);
                end
                4'd1: begin
                    init_single = 1'b1;
                    init_wait   = 32'(INIT_WAIT_2);
                end
                4'd2: init_single = 1'b1;
                4'd3: begin
                    init_single = 1'b1;
                    init_byte   = 8'h20;
                end
                4'd4: init_byte = 8'h28;
                4'd5: init_byte = 8'h06;
                4'd6: init_byte = 8'h0C;
                4'd7: begin
                    init_byte = 8'h01;
                    init_wait = 32'(CLEAR_WAIT);
                end
                default: ;
            endcase
        end else begin
            case (idx_q)
                4'd0: init_wait = 32'(INIT_WAIT_1);
                4'd1: init_wait = 32'(INIT_WAIT_2);
                4'd2: ;
                4'd3: init_byte = 8'h38;
                4'd4: init_byte = 8'h06;
                4'd5: init_byte = 8'h0C;
                4'd6: begin
                    init_byte = 8'h01;
                    init_wait = 32'(CLEAR_WAIT);
                end
                default: ;
            endcase
        end
    end

    // Cursor bookkeeping for the request currently on the handshake.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        post_d = 32'(CMD_WAIT);
`ifdef LCD_AUTO_WRAP_EN
        wrap_d = 1'b0;
`endif
        if (!CHAR_CMD) begin
            if (col_q == 6'(COLS - 1)) begin
                col_d = 6'd0;
                row_d = (ROWS > 1) ? ~row_q : 1'b0;
`ifdef LCD_AUTO_WRAP_EN
                wrap_d = 1'b1;
`endif
            end else begin
                col_d = col_q + 6'd1;
            end
        end else if (CHAR_DATA == 8'h01 || CHAR_DATA == 8'h02) begin
            col_d  = 6'd0;
            row_d  = 1'b0;
            post_d = 32'(CLEAR_WAIT);
        end else if (CHAR_DATA[7]) begin
            col_d = CHAR_DATA[5:0];
            row_d = (ROWS > 1) ? CHAR_DATA[6] : 1'b0;
        end
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (BTN_SOUTH) begin
            state_q  <= S_PWR;
            cnt_q    <= 32'd0;
            wait_q   <= 32'd0;
            idx_q    <= 4'd0;
            byte_q   <= 8'h00;
            db_q     <= 8'h00;
            rs_q     <= 1'b0;
            e_q      <= 1'b0;
            single_q <= 1'b0;
            nib_q    <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            col_q    <= 6'd0;
            row_q    <= 1'b0;
`ifdef LCD_AUTO_WRAP_EN
            wrap_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_PWR: begin
                    if (cnt_q == 32'(PWR_WAIT - 1)) begin
                        cnt_q   <= 32'd0;
                        idx_q   <= 4'd0;
                        state_q <= S_INIT;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_INIT: begin
                    if (idx_q == 4'(INIT_N)) begin
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        byte_q   <= init_byte;
                        db_q     <= bus_val(init_byte, 1'b0);
                        rs_q     <= 1'b0;
                        wait_q   <= init_wait;
                        single_q <= init_single;
                        nib_q    <= 1'b0;
                        idx_q    <= idx_q + 4'd1;
                        cnt_q    <= 32'd0;
                        state_q  <= S_SETUP;
                    end
                end
                S_IDLE: begin
                    if (CHAR_VALID && ready_q) begin
                        ready_q  <= 1'b0;
                        byte_q   <= CHAR_DATA;
                        db_q     <= bus_val(CHAR_DATA, 1'b0);
                        rs_q     <= ~CHAR_CMD;
                        wait_q   <= post_d;
                        single_q <= 1'b0;
                        nib_q    <= 1'b0;
                        col_q    <= col_d;
                        row_q    <= row_d;
`ifdef LCD_AUTO_WRAP_EN
                        wrap_q   <= wrap_d;
`endif
                        cnt_q    <= 32'd0;
                        state_q  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt_q == 32'(SETUP_WAIT - 1)) begin
                        e_q     <= 1'b1;
                        cnt_q   <= 32'd0;
                        state_q <= S_EHIGH;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_EHIGH: begin
                    if (cnt_q == 32'(E_WAIT - 1)) begin
                        e_q     <= 1'b0;
                        cnt_q   <= 32'd0;
                        state_q <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_HOLD: begin
                    // High nibble of a full byte: short gap, then low nibble.
                    if (BUS_4BIT != 0 && !single_q && !nib_q) begin
                        if (cnt_q == 32'(CMD_WAIT - 1)) begin
                            nib_q   <= 1'b1;
                            db_q    <= bus_val(byte_q, 1'b1);
                            cnt_q   <= 32'd0;
                            state_q <= S_SETUP;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end else if (cnt_q == wait_q - 32'd1) begin
                        cnt_q <= 32'd0;
                        if (!done_q) begin
                            state_q <= S_INIT;
                        end
`ifdef LCD_AUTO_WRAP_EN
                        else if (wrap_q) begin
                            state_q <= S_WRAP;
                        end
`endif
                        else begin
                            ready_q <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
`ifdef LCD_AUTO_WRAP_EN
                S_WRAP: begin
                    byte_q   <= {1'b1, row_q, 6'h00};
                    db_q     <= bus_val({1'b1, row_q, 6'h00}, 1'b0);
                    rs_q     <= 1'b0;
                    wait_q   <= 32'(CMD_WAIT);
                    single_q <= 1'b0;
                    nib_q    <= 1'b0;
                    wrap_q   <= 1'b0;
                    cnt_q    <= 32'd0;
                    state_q  <= S_SETUP;
                end
`endif
                default: state_q <= S_PWR;
            endcase
        end
    end

    assign CHAR_READY = ready_q;
    assign INIT_DONE  = done_q;
    assign LCD_DB     = db_q;
    assign LCD_E      = e_q;
    assign LCD_RS     = rs_q;
    assign LCD_RW     = 1'b0;
    assign LED        = {done_q, row_q, state_q};

endmodule
